// File: rtl/vdmem_strided_if.sv
// vdmem_strided_if: request/response bundle for the strided vector data memory.
//   master modport : request producer (datapath / testbench)
//   slave  modport : vdmem_strided
// Signals:
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_base/req_stride : word address of element 0 and two's-complement stride
//   req_len             : element count 0..MAX_ELEMS
//   req_wdata           : store data, element i at [i*DATA_W +: DATA_W]
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata           : registered load result, same packing as req_wdata
//   rsp_err             : out-of-range access seen during the request
//   busy                : request in flight
interface vdmem_strided_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_ELEMS = 16
);
  localparam int LEN_W = $clog2(MAX_ELEMS + 1);

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [ADDR_W-1:0]           req_base;
  logic [ADDR_W-1:0]           req_stride;
  logic [LEN_W-1:0]            req_len;
  logic [MAX_ELEMS*DATA_W-1:0] req_wdata;
  logic                        rsp_valid;
  logic [MAX_ELEMS*DATA_W-1:0] rsp_rdata;
  logic                        rsp_err;
  logic                        busy;

  modport master (
    output req_valid, req_we, req_base, req_stride, req_len, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_base, req_stride, req_len, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/vdmem_strided.sv
// vdmem_strided: vector data memory serving one strided load/store request at a
// time, LANES elements per clock. A request is split into ceil(len/LANES) beats;
// the load result is returned as one registered response.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : vdmem_strided_if.slave request/response bundle
// Build option:
//   VDMEM_BOUNDS_CHECK_EN : when defined, element addresses >= DEPTH neither
//   write nor read (read as 0) and raise rsp_err; when undefined, the address
//   is truncated to the RAM index width (wraps) and rsp_err is 0.
module vdmem_strided #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    LANES     = 4,
  parameter int    MAX_ELEMS = 16,
  parameter int    ADDR_W    = 32,
  parameter string INIT_FILE = ""
) (
  input logic            clk,
  input logic            rst,
  vdmem_strided_if.slave bus
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LEN_W  = $clog2(MAX_ELEMS + 1);
  localparam int NBEATS = MAX_ELEMS / LANES;
  localparam int BEAT_W = $clog2(NBEATS) + 1;
  localparam int VEC_W  = MAX_ELEMS * DATA_W;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  beat_addr_q, beat_addr_d;   // address of the beat's lane 0
  logic [ADDR_W-1:0]  stride_q, stride_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [VEC_W-1:0]   wdata_q, wdata_d;           // shifted down one beat per beat
  logic [VEC_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]   lane_idx   [LANES];
  logic [DATA_W-1:0]  lane_rdata [LANES];
  logic [LANES-1:0]   lane_act;
  logic [LANES-1:0]   lane_oob;
  logic [LANES-1:0]   lane_wen;
  logic               last_beat;

  // Per-lane address decode for the current beat.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef VDMEM_BOUNDS_CHECK_EN
    logic [ADDR_W-1:0] lane_addr;
    assign lane_addr    = beat_addr_q + stride_q * ADDR_W'(gi);
    assign lane_idx[gi] = lane_addr[IDX_W-1:0];
    assign lane_oob[gi] = (lane_addr >= ADDR_W'(DEPTH));
`else
    assign lane_idx[gi] = IDX_W'(beat_addr_q + stride_q * ADDR_W'(gi));
    assign lane_oob[gi] = 1'b0;
`endif
    assign lane_act[gi]   = (32'(beat_q) * 32'(LANES) + 32'(gi)) < 32'(len_q);
    assign lane_wen[gi]   = (state_q == BUSY) && we_q && lane_act[gi] && !lane_oob[gi];
    assign lane_rdata[gi] = lane_oob[gi] ? '0 : mem[lane_idx[gi]];
  end

  // A zero-length request still spends one empty beat, so every response
  // arrives max(B,1) cycles after accept.
  assign last_beat = ((32'(beat_q) + 32'd1) * 32'(LANES)) >= 32'(len_q);

  // Lanes are applied in ascending order, so when several lanes of one beat
  // hit the same word the highest element index lands last and wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_wen[l]) mem[lane_idx[l]] <= wdata_q[l*DATA_W +: DATA_W];
      end
    end
  end

`ifdef VDMEM_BOUNDS_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    beat_addr_d = beat_addr_q;
    stride_d    = stride_q;
    len_d       = len_q;
    beat_d      = beat_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
`ifdef VDMEM_BOUNDS_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d     = BUSY;
          we_d        = bus.req_we;
          beat_addr_d = bus.req_base;
          stride_d    = bus.req_stride;
          len_d       = bus.req_len;
          wdata_d     = bus.req_wdata;
          rdata_d     = '0;
          beat_d      = '0;
`ifdef VDMEM_BOUNDS_CHECK_EN
          err_d       = 1'b0;
`endif
        end
      end
      BUSY: begin
        if (!we_q) begin
          for (int j = 0; j < NBEATS; j++) begin
            for (int l = 0; l < LANES; l++) begin
              if ((32'(beat_q) == 32'(j)) && lane_act[l]) begin
                rdata_d[(j*LANES+l)*DATA_W +: DATA_W] = lane_rdata[l];
              end
            end
          end
        end
`ifdef VDMEM_BOUNDS_CHECK_EN
        err_d = err_q | (|(lane_act & lane_oob));
`endif
        wdata_d     = wdata_q >> (LANES * DATA_W);
        beat_addr_d = beat_addr_q + stride_q * ADDR_W'(LANES);
        beat_d      = beat_q + BEAT_W'(1);
        if (last_beat) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      beat_addr_q <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
`ifdef VDMEM_BOUNDS_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      beat_addr_q <= beat_addr_d;
      stride_q    <= stride_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
`ifdef VDMEM_BOUNDS_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
`ifdef VDMEM_BOUNDS_CHECK_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_vdmem_strided.sv
// Directed bench for vdmem_strided with an element-by-element reference model
// and a scoreboard of expected responses.
module tb_vdmem_strided;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int LANES = 4;
  localparam int ME    = 16;
  localparam int AW    = 32;
  localparam int LW    = $clog2(ME + 1);
  localparam int VW    = ME * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vdmem_strided_if #(.DATA_W(DW), .ADDR_W(AW), .MAX_ELEMS(ME)) bus ();

  vdmem_strided #(
    .DATA_W(DW), .DEPTH(DEPTH), .LANES(LANES), .MAX_ELEMS(ME), .ADDR_W(AW), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [VW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mm [DEPTH];
  int            checks = 0;
  int            passes = 0;
  int            fails  = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: elements processed in index order, so later elements win on
  // address collisions.
  task automatic model(input bit we, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                       input int len, input logic [VW-1:0] wd,
                       output logic [VW-1:0] rd, output logic err);
    logic [AW-1:0] a;
    rd  = '0;
    err = 1'b0;
    for (int i = 0; i < len; i++) begin
      a = base + stride * AW'(i);
`ifdef VDMEM_BOUNDS_CHECK_EN
      if (a >= AW'(DEPTH)) begin
        err = 1'b1;
        continue;
      end
`endif
      if (we) mm[a % DEPTH] = wd[i*DW +: DW];
      else    rd[i*DW +: DW] = mm[a % DEPTH];
    end
  endtask

  task automatic drive(input bit we, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                       input int len, input logic [VW-1:0] wd);
    bus.req_we     = we;
    bus.req_base   = base;
    bus.req_stride = stride;
    bus.req_len    = LW'(len);
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
  endtask

  task automatic issue(input string tag, input bit we, input logic [AW-1:0] base,
                       input logic [AW-1:0] stride, input int len, input logic [VW-1:0] wd);
    exp_t e;
    int   lat;
    model(we, base, stride, len, wd, e.rdata, e.err);
    e.lat = (len == 0) ? 1 : (len + LANES - 1) / LANES;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, " ready"}, VW'(bus.req_ready), VW'(1));
    drive(we, base, stride, len, wd);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, " busy"}, VW'(bus.busy), VW'(1));
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, VW'(lat), VW'(e.lat));
    chk({tag, " rdata"}, bus.rsp_rdata, e.rdata);
    chk({tag, " err"}, VW'(bus.rsp_err), VW'(e.err));
    @(negedge clk);
    chk({tag, " pulse_end"}, VW'(bus.rsp_valid), VW'(0));
    $display("txn %s we=%0d base=%0h stride=%0h len=%0d lat=%0d err=%0d",
             tag, we, base, stride, len, lat, bus.rsp_err);
  endtask

  initial begin
    logic [VW-1:0] wd;
    logic [VW-1:0] rdx;
    logic          errx;
    logic [AW-1:0] b;
    logic [AW-1:0] s;
    int            n;

    for (int i = 0; i < DEPTH; i++) mm[i] = 'x;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_base = '0;
    bus.req_stride = '0;
    bus.req_len = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset ready", VW'(bus.req_ready), VW'(1));
    chk("reset busy", VW'(bus.busy), VW'(0));
    chk("reset rsp_valid", VW'(bus.rsp_valid), VW'(0));
    chk("reset rdata", bus.rsp_rdata, '0);
    chk("reset err", VW'(bus.rsp_err), VW'(0));

    // Unit-stride store then load
    wd = '0;
    for (int i = 0; i < 8; i++) wd[i*DW +: DW] = 32'h100 + 32'(i);
    issue("st_unit", 1'b1, 32'h10, 32'd1, 8, wd);
    issue("ld_unit", 1'b0, 32'h10, 32'd1, 8, '0);

    // Negative stride: preload RAM[0x20-i]=i, then gather
    wd = '0;
    for (int i = 0; i < 5; i++) wd[i*DW +: DW] = 32'(i);
    issue("st_neg", 1'b1, 32'h20, 32'hFFFF_FFFF, 5, wd);
    issue("ld_neg", 1'b0, 32'h20, 32'hFFFF_FFFF, 5, '0);
    issue("ld_neg_unit", 1'b0, 32'h1C, 32'd1, 5, '0);

    // Same-address store: highest element wins
    wd = '0;
    for (int i = 0; i < 4; i++) wd[i*DW +: DW] = 32'hA + 32'(i);
    issue("st_same", 1'b1, 32'h40, 32'd0, 4, wd);
    issue("ld_same", 1'b0, 32'h40, 32'd1, 1, '0);

    // Zero length
    issue("ld_len0", 1'b0, 32'h10, 32'd1, 0, '0);

    // Full-length strided store/load
    wd = '0;
    for (int i = 0; i < ME; i++) wd[i*DW +: DW] = 32'h9000 + 32'(i * 7);
    issue("st_full", 1'b1, 32'h100, 32'd3, ME, wd);
    issue("ld_full", 1'b0, 32'h100, 32'd3, ME, '0);

    // Mid-operation reset: prefill, then interrupt a 16-element store after beat 1
    wd = '0;
    for (int i = 0; i < ME; i++) wd[i*DW +: DW] = 32'hEE;
    issue("st_fill", 1'b1, 32'h200, 32'd1, ME, wd);
    wd = '0;
    for (int i = 0; i < ME; i++) wd[i*DW +: DW] = 32'h500 + 32'(i);
    @(negedge clk);
    drive(1'b1, 32'h200, 32'd1, ME, wd);
    @(negedge clk);           // after accept edge
    bus.req_valid = 1'b0;
    @(negedge clk);           // after beat 0
    @(negedge clk);           // after beat 1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mm[32'h200 + i] = 32'h500 + 32'(i);
    chk("midrst ready", VW'(bus.req_ready), VW'(1));
    chk("midrst busy", VW'(bus.busy), VW'(0));
    chk("midrst rsp_valid", VW'(bus.rsp_valid), VW'(0));
    chk("midrst rdata", bus.rsp_rdata, '0);
    $display("txn midrst store interrupted after beat 1");
    issue("ld_midrst", 1'b0, 32'h200, 32'd1, ME, '0);

    // Bounds: known contents at both ends, then a load straddling DEPTH
    wd = '0;
    wd[0 +: DW] = 32'h777;
    wd[DW +: DW] = 32'h778;
    issue("st_low", 1'b1, 32'h0, 32'd1, 2, wd);
    wd[0 +: DW] = 32'h3FE;
    wd[DW +: DW] = 32'h3FF;
    issue("st_high", 1'b1, AW'(DEPTH - 2), 32'd1, 2, wd);
    model(1'b0, AW'(DEPTH - 2), 32'd1, 4, '0, rdx, errx);
`ifdef VDMEM_BOUNDS_CHECK_EN
    chk("bounds ref", rdx, {{(ME-4)*DW{1'b0}}, 32'h0, 32'h0, 32'h3FF, 32'h3FE});
`else
    chk("bounds ref", rdx, {{(ME-4)*DW{1'b0}}, 32'h778, 32'h777, 32'h3FF, 32'h3FE});
`endif
    issue("ld_bounds", 1'b0, AW'(DEPTH - 2), 32'd1, 4, '0);

    // A few random strided store/load pairs
    for (int t = 0; t < 3; t++) begin
      b = 32'h300 + AW'($urandom_range(0, 240));
      s = AW'($urandom_range(0, 6)) - 32'd3;
      n = $urandom_range(1, ME);
      wd = '0;
      for (int i = 0; i < ME; i++) wd[i*DW +: DW] = $urandom;
      issue("st_rand", 1'b1, b, s, n, wd);
      issue("ld_rand", 1'b0, b, s, n, '0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
